// File: rtl/mem_pkg.sv
//==============================================================================
// mem_pkg : shared state encodings, default widths and bus-error read value
// Rev 1.0
//==============================================================================
`default_nettype none

package mem_pkg;

   localparam int c_ADDR_W       = 16;
   localparam int c_DATA_W       = 16;
   localparam int c_DEPTH_LOG2   = 10;
   localparam int c_WAIT_W       = 4;
   localparam int c_BUSERR_RDATA = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } memState_t;

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_array.sv
//==============================================================================
// mem_array : synchronous single-port RAM, read-first, no reset on contents
// Rev 1.0
//==============================================================================
`default_nettype none

module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_W     = c_DATA_W,
   parameter int DEPTH_LOG2 = c_DEPTH_LOG2
)
(
   input  logic                  CLK,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

   always_ff @(posedge CLK) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
      rdata <= r_mem[addr];
   end

endmodule : mem_array

`default_nettype wire

// File: rtl/mem_responder.sv
//==============================================================================
// mem_responder : wait-state memory responder with one-cycle MemReady pulse
//                 optional bus-error reporting via macro MEM_RESP_BUSERR_EN
// Rev 1.0
//==============================================================================
`default_nettype none

module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = c_ADDR_W,
   parameter int DATA_W      = c_DATA_W,
   parameter int DEPTH_LOG2  = c_DEPTH_LOG2,
   parameter int WAIT_STATES = 2
)
(
   input  logic              CLK,
   input  logic              Reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData,
   output logic              MemReady,
   output logic              MemBusy,
`ifdef MEM_RESP_BUSERR_EN
   output logic              MemError,
`endif
   output logic [1:0]        current_state
);

   memState_t             r_state;
   memState_t             w_nextState;
   memState_t             w_acceptState;
   logic [c_WAIT_W-1:0]   r_waitCnt;
   logic [DEPTH_LOG2-1:0] r_wordIdx;
   logic [DATA_W-1:0]     r_writeData;
   logic [DATA_W-1:0]     r_readData;
   logic                  r_isWrite;
   logic                  r_busErr;

   logic                  w_request;
   logic                  w_accept;
   logic                  w_enterResp;
   logic                  w_reqBusErr;
   logic [DEPTH_LOG2-1:0] w_curIdx;
   logic [DATA_W-1:0]     w_curWData;
   logic                  w_curIsWrite;
   logic                  w_curBusErr;
   logic                  w_ramWe;
   logic [DATA_W-1:0]     w_ramRdata;
   logic                  w_respRead;
   logic [DATA_W-1:0]     w_respRdata;

   assign w_request = MemRead | MemWrite;
   assign w_accept  = (r_state == IDLE) && w_request;

`ifdef MEM_RESP_BUSERR_EN
   assign w_reqBusErr = (|Address[ADDR_W-1:DEPTH_LOG2+1]) | Address[0];
   assign MemError    = (r_state == RESP) && r_busErr;
`else
   logic w_unusedAddrBits;
   assign w_reqBusErr      = 1'b0;
   assign w_unusedAddrBits = ^{Address[ADDR_W-1:DEPTH_LOG2+1], Address[0]};
`endif

   generate
      if (WAIT_STATES == 0) begin : g_noWait
         assign w_acceptState = RESP;
      end else begin : g_waitStates
         assign w_acceptState = WAIT;
      end
   endgenerate

   // In IDLE the accepting request is still on the live inputs; afterwards use latched copies
   assign w_curIdx     = (r_state == IDLE) ? Address[DEPTH_LOG2:1] : r_wordIdx;
   assign w_curWData   = (r_state == IDLE) ? WriteData : r_writeData;
   assign w_curIsWrite = (r_state == IDLE) ? MemWrite : r_isWrite;
   assign w_curBusErr  = (r_state == IDLE) ? w_reqBusErr : r_busErr;
   assign w_ramWe      = w_enterResp && w_curIsWrite && !w_curBusErr;

   mem_array #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .CLK   (CLK),
      .we    (w_ramWe),
      .addr  (w_curIdx),
      .wdata (w_curWData),
      .rdata (w_ramRdata)
   );

   always_comb begin
      w_nextState = r_state;
      w_enterResp = 1'b0;
      MemReady    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_request) begin
               w_nextState = w_acceptState;
               w_enterResp = (w_acceptState == RESP);
            end
         end
         WAIT: begin
            if (r_waitCnt <= 4'd1) begin
               w_nextState = RESP;
               w_enterResp = 1'b1;
            end
         end
         RESP: begin
            MemReady    = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // The RAM word read on the edge entering RESP is presented during RESP and then held
   assign w_respRead  = (r_state == RESP) && !r_isWrite;
   assign w_respRdata = r_busErr ? DATA_W'(c_BUSERR_RDATA) : w_ramRdata;
   assign ReadData    = w_respRead ? w_respRdata : r_readData;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_waitCnt   <= '0;
         r_wordIdx   <= '0;
         r_writeData <= '0;
         r_readData  <= '0;
         r_isWrite   <= 1'b0;
         r_busErr    <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_wordIdx   <= Address[DEPTH_LOG2:1];
            r_writeData <= WriteData;
            r_isWrite   <= MemWrite;
            r_busErr    <= w_reqBusErr;
            r_waitCnt   <= c_WAIT_W'(WAIT_STATES);
         end else if (r_state == WAIT) begin
            r_waitCnt <= r_waitCnt - 4'd1;
         end
         if (w_respRead) begin
            r_readData <= w_respRdata;
         end
      end
   end

   assign MemBusy       = (r_state != IDLE);
   assign current_state = r_state;

endmodule : mem_responder

`default_nettype wire

// File: tb/tb_mem_responder.sv
//==============================================================================
// tb_mem_responder : scoreboard bench for mem_responder (WAIT_STATES 0 and 2)
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_mem_responder;

`ifdef MEM_RESP_BUSERR_EN
   localparam bit BE = 1'b1;
`else
   localparam bit BE = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
   logic [15:0] a0 = '0, wd0 = '0, a1 = '0, wd1 = '0;
   wire  [15:0] rdata0, rdata1;
   wire         rdy0, rdy1, busy0, busy1;
   wire  [1:0]  st0, st1;
`ifdef MEM_RESP_BUSERR_EN
   wire         err0, err1;
`endif

   always #5 CLK = ~CLK;

   mem_responder #(.WAIT_STATES(0)) dut0 (
      .CLK(CLK), .Reset(Reset), .MemRead(rd0), .MemWrite(wr0), .Address(a0),
      .WriteData(wd0), .ReadData(rdata0), .MemReady(rdy0), .MemBusy(busy0),
`ifdef MEM_RESP_BUSERR_EN
      .MemError(err0),
`endif
      .current_state(st0));

   mem_responder #(.WAIT_STATES(2)) dut1 (
      .CLK(CLK), .Reset(Reset), .MemRead(rd1), .MemWrite(wr1), .Address(a1),
      .WriteData(wd1), .ReadData(rdata1), .MemReady(rdy1), .MemBusy(busy1),
`ifdef MEM_RESP_BUSERR_EN
      .MemError(err1),
`endif
      .current_state(st1));

   typedef struct {
      int          rdyCyc;
      bit          chk;
      logic [15:0] data;
      bit          err;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic on_ready(input int w, input logic [15:0] rdata, input logic busy);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (w == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (w == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
         checks++;
         failures++;
         $display("FAIL unexpected_ready dut%0d actual=1 required=0 (cyc %0d)", w, cyc);
      end else begin
         check($sformatf("latency_dut%0d", w), cyc, e.rdyCyc);
         check($sformatf("busy_in_resp_dut%0d", w), {31'd0, busy}, 32'd1);
         if (e.chk) check($sformatf("readdata_dut%0d", w), {16'd0, rdata}, {16'd0, e.data});
`ifdef MEM_RESP_BUSERR_EN
         check($sformatf("memerror_dut%0d", w), {31'd0, (w == 0) ? err0 : err1}, {31'd0, e.err});
`endif
      end
   endtask

   // Monitor: compare every MemReady pulse against the oldest pending expectation
   always @(posedge CLK) begin
      #1;
      if (rdy0 === 1'b1) on_ready(0, rdata0, busy0);
      if (rdy1 === 1'b1) on_ready(1, rdata1, busy1);
   end

   task automatic drive(input int w, input bit r, input bit wr, input logic [15:0] a, input logic [15:0] d);
      if (w == 0) begin rd0 = r; wr0 = wr; a0 = a; wd0 = d; end
      else        begin rd1 = r; wr1 = wr; a1 = a; wd1 = d; end
   endtask

   // Called at a negedge; b2b means issued during the previous RESP, so accepted one cycle later
   task automatic req(input int w, input bit r, input bit wr, input logic [15:0] a,
                      input logic [15:0] d, input bit chk, input logic [15:0] expd,
                      input bit experr, input bit b2b, input bit mangle);
      exp_t e;
      int   acc;
      bit   seen;
      drive(w, r, wr, a, d);
      acc      = b2b ? cyc + 1 : cyc;
      e.rdyCyc = acc + ((w == 0) ? 0 : 2) + 1;
      e.chk    = chk;
      e.data   = expd;
      e.err    = experr;
      if (w == 0) q0.push_back(e); else q1.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge CLK);
         #1;
         seen = (w == 0) ? rdy0 : rdy1;
         if (mangle && i == 0 && !seen) begin
            @(negedge CLK);
            drive(w, 1'b0, 1'b0, ~a, ~d);
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL timeout_dut%0d actual=no_ready required=ready", w);
      end
      @(negedge CLK);
      drive(w, 1'b0, 1'b0, a, d);
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("reset_ready0", {31'd0, rdy0}, 32'd0);
      check("reset_busy0",  {31'd0, busy0}, 32'd0);
      check("reset_rdata0", {16'd0, rdata0}, 32'd0);
      check("reset_state0", {30'd0, st0}, 32'd0);
      check("reset_ready1", {31'd0, rdy1}, 32'd0);
      check("reset_busy1",  {31'd0, busy1}, 32'd0);
      check("reset_rdata1", {16'd0, rdata1}, 32'd0);
      check("reset_state1", {30'd0, st1}, 32'd0);
      Reset = 1'b0;
      @(negedge CLK);

      // WAIT_STATES=2: write/read, hold, both strobes, changes while busy
      req(1, 0, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 0, 0, 0);
      @(negedge CLK);
      req(1, 1, 0, 16'h0010, 16'h0000, 1, 16'hBEEF, 0, 0, 0);
      repeat (3) @(negedge CLK);
      check("readdata_held", {16'd0, rdata1}, 32'h0000BEEF);
      req(1, 1, 1, 16'h0004, 16'h5A5A, 1, 16'hBEEF, 0, 0, 0);
      @(negedge CLK);
      req(1, 1, 0, 16'h0004, 16'h0000, 1, 16'h5A5A, 0, 0, 0);
      @(negedge CLK);
      req(1, 0, 1, 16'h0030, 16'h7777, 0, 16'h0000, 0, 0, 1);
      @(negedge CLK);
      req(1, 1, 0, 16'h0030, 16'h0000, 1, 16'h7777, 0, 0, 0);

      // Reset during the first WAIT cycle discards the write
      @(negedge CLK);
      req(1, 0, 1, 16'h0020, 16'h1111, 0, 16'h0000, 0, 0, 0);
      @(negedge CLK);
      drive(1, 1'b0, 1'b1, 16'h0020, 16'hAAAA);
      @(negedge CLK);
      check("midreset_state_wait", {30'd0, st1}, 32'd1);
      check("midreset_busy_wait", {31'd0, busy1}, 32'd1);
      Reset = 1'b1;
      drive(1, 1'b0, 1'b0, 16'h0020, 16'hAAAA);
      @(negedge CLK);
      Reset = 1'b0;
      check("midreset_state", {30'd0, st1}, 32'd0);
      check("midreset_busy", {31'd0, busy1}, 32'd0);
      check("midreset_ready", {31'd0, rdy1}, 32'd0);
      check("midreset_rdata", {16'd0, rdata1}, 32'd0);
      repeat (4) @(negedge CLK);
      req(1, 1, 0, 16'h0020, 16'h0000, 1, 16'h1111, 0, 0, 0);

      // Out-of-range and odd addresses
      @(negedge CLK);
      req(1, 0, 1, 16'h0000, 16'hC0DE, 0, 16'h0000, 0, 0, 0);
      @(negedge CLK);
      req(1, 1, 0, 16'h0800, 16'h0000, 1, BE ? 16'h0000 : 16'hC0DE, BE, 0, 0);
      @(negedge CLK);
      req(1, 1, 0, 16'h0011, 16'h0000, 1, BE ? 16'h0000 : 16'hBEEF, BE, 0, 0);

      // WAIT_STATES=0 back-to-back
      @(negedge CLK);
      req(0, 0, 1, 16'h0002, 16'h1234, 0, 16'h0000, 0, 0, 0);
      req(0, 1, 0, 16'h0002, 16'h0000, 1, 16'h1234, 0, 1, 0);
      req(0, 0, 1, 16'h0006, 16'h4321, 1, 16'h1234, 0, 1, 0);
      req(0, 1, 0, 16'h0006, 16'h0000, 1, 16'h4321, 0, 1, 0);

      repeat (5) @(negedge CLK);
      check("pending_dut0", q0.size(), 32'd0);
      check("pending_dut1", q1.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mem_responder

`default_nettype wire
